sonar_range_filter: RTL and testbench

- Consumes raw echo-width counts (clock ticks) from the sonar front end, one strobe per measurement cycle.
- Converts each count to millimetres and clamps out-of-range and no-echo samples.
- Median-of-3 filters the result, drives an obstacle flag with hysteresis, and flags stale data when samples stop arriving.
- Sits between the sonar front end and the motion-control logic.

---
 rtl/sonar_pkg.sv | 44 ++++
 rtl/sonar_range_filter_median3.sv | 34 +++
 rtl/sonar_range_filter.sv | 172 +++++++++++++++++
 tb/tb_sonar_range_filter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types, default constants and the tick-to-millimetre conversion
// for the sonar range filter and anything that models it.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALE  = 2'd1,
        SORT   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int unsigned SCALE_MUL_DEF       = 225;
    localparam int unsigned SCALE_SHIFT_DEF     = 16;
    localparam int unsigned TIMEOUT_TICKS_DEF   = 1_900_000;
    localparam int unsigned RANGE_MAX_MM_DEF    = 6000;
    localparam int unsigned NEAR_MM_DEF         = 300;
    localparam int unsigned HYST_MM_DEF         = 50;
    localparam int unsigned WATCHDOG_CYCLES_DEF = 10_000_000;

    // Echo ticks to mm: 32x16 multiply kept at 48 bits, shifted, then clamped.
    // A count at or beyond the timeout is a missing echo and reads as max range.
    function automatic logic [15:0] ticks_to_mm(
        input logic [31:0] raw,
        input logic [15:0] mul,
        input logic [5:0]  shift,
        input logic [31:0] timeout,
        input logic [15:0] max_mm
    );
        logic [47:0] prod;
        logic [47:0] shifted;
        logic [15:0] result;
        prod    = {16'd0, raw} * {32'd0, mul};
        shifted = prod >> shift;
        if (raw >= timeout) begin
            result = max_mm;
        end else if (shifted > {32'd0, max_mm}) begin
            result = max_mm;
        end else begin
            result = shifted[15:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/sonar_range_filter_median3.sv
// Combinational median of three unsigned 16-bit values.
module median3 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    output logic [15:0] med_o
);

    logic [15:0] lo_s;
    logic [15:0] hi_s;
    logic [15:0] hi_c_s;

    // median = max(min(a,b), min(max(a,b),c))
    always_comb begin
        if (a_i < b_i) begin
            lo_s = a_i;
            hi_s = b_i;
        end else begin
            lo_s = b_i;
            hi_s = a_i;
        end
        if (hi_s < c_i) begin
            hi_c_s = hi_s;
        end else begin
            hi_c_s = c_i;
        end
        if (lo_s > hi_c_s) begin
            med_o = lo_s;
        end else begin
            med_o = hi_c_s;
        end
    end

endmodule

// File: rtl/sonar_range_filter.sv
// Sonar echo-width to distance filter: scale/clamp, median-of-3, obstacle
// flag with hysteresis, stale-data watchdog and sticky overrun.
module sonar_range_filter
    import sonar_pkg::*;
#(
    parameter int unsigned SCALE_MUL       = SCALE_MUL_DEF,
    parameter int unsigned SCALE_SHIFT     = SCALE_SHIFT_DEF,
    parameter int unsigned TIMEOUT_TICKS   = TIMEOUT_TICKS_DEF,
    parameter int unsigned RANGE_MAX_MM    = RANGE_MAX_MM_DEF,
    parameter int unsigned NEAR_MM         = NEAR_MM_DEF,
    parameter int unsigned HYST_MM         = HYST_MM_DEF,
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_valid,
    input  logic [31:0] raw_dist,
    output logic [15:0] dist_mm,
    output logic        dist_valid,
    output logic        obstacle,
    output logic        stale,
    output logic        overrun
);

    localparam logic [15:0] MUL_L     = 16'(SCALE_MUL);
    localparam logic [5:0]  SHIFT_L   = 6'(SCALE_SHIFT);
    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_TICKS);
    localparam logic [15:0] MAX_L     = 16'(RANGE_MAX_MM);
    localparam logic [15:0] NEAR_L    = 16'(NEAR_MM);
    localparam logic [15:0] REL_L     = 16'(NEAR_MM + HYST_MM);
    localparam logic [31:0] WD_L      = 32'(WATCHDOG_CYCLES);

    state_t      state_q,      state_d;
    logic [31:0] raw_q,        raw_d;
    logic [15:0] h0_q,         h0_d;
    logic [15:0] h1_q,         h1_d;
    logic [15:0] h2_q,         h2_d;
    logic [1:0]  fill_q,       fill_d;
    logic [31:0] wd_q,         wd_d;
    logic [15:0] dist_mm_q,    dist_mm_d;
    logic        dist_valid_q, dist_valid_d;
    logic        obstacle_q,   obstacle_d;
    logic        stale_q,      stale_d;
    logic        overrun_q,    overrun_d;

    logic [15:0] sample_s;
    logic [15:0] med_s;
    logic [15:0] filt_s;

    assign sample_s = ticks_to_mm(raw_q, MUL_L, SHIFT_L, TIMEOUT_L, MAX_L);

    median3 u_median3 (
        .a_i   (h0_q),
        .b_i   (h1_q),
        .c_i   (h2_q),
        .med_o (med_s)
    );

    // With only two samples the nearer one wins, so a real obstacle is never hidden.
    always_comb begin
        case (fill_q)
            2'd1: filt_s = h0_q;
            2'd2: filt_s = (h0_q < h1_q) ? h0_q : h1_q;
            default: filt_s = med_s;
        endcase
    end

    // Next-state, datapath and flag logic.
    always_comb begin
        state_d      = state_q;
        raw_d        = raw_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        fill_d       = fill_q;
        dist_mm_d    = dist_mm_q;
        dist_valid_d = 1'b0;
        obstacle_d   = obstacle_q;
        wd_d         = (wd_q < WD_L) ? (wd_q + 32'd1) : wd_q;

        case (state_q)
            IDLE: begin
                if (raw_valid) begin
                    raw_d   = raw_dist;
                    wd_d    = 32'd0;
                    state_d = SCALE;
                end else begin
                    state_d = IDLE;
                end
            end
            SCALE: begin
                h0_d    = sample_s;
                h1_d    = h0_q;
                h2_d    = h1_q;
                fill_d  = (fill_q == 2'd3) ? 2'd3 : (fill_q + 2'd1);
                state_d = SORT;
            end
            SORT: begin
                // Outputs register here so they are visible during UPDATE.
                dist_mm_d    = filt_s;
                dist_valid_d = 1'b1;
                if (filt_s < NEAR_L) begin
                    obstacle_d = 1'b1;
                end else if (filt_s > REL_L) begin
                    obstacle_d = 1'b0;
                end else begin
                    obstacle_d = obstacle_q;
                end
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (raw_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // A fresh distance always beats a watchdog expiry.
        if (state_q == SORT) begin
            stale_d = 1'b0;
        end else if (wd_d >= WD_L) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            raw_q        <= 32'd0;
            h0_q         <= 16'd0;
            h1_q         <= 16'd0;
            h2_q         <= 16'd0;
            fill_q       <= 2'd0;
            wd_q         <= 32'd0;
            dist_mm_q    <= MAX_L;
            dist_valid_q <= 1'b0;
            obstacle_q   <= 1'b0;
            stale_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            raw_q        <= raw_d;
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            fill_q       <= fill_d;
            wd_q         <= wd_d;
            dist_mm_q    <= dist_mm_d;
            dist_valid_q <= dist_valid_d;
            obstacle_q   <= obstacle_d;
            stale_q      <= stale_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dist_mm    = dist_mm_q;
    assign dist_valid = dist_valid_q;
    assign obstacle   = obstacle_q;
    assign stale      = stale_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sonar_range_filter.sv
// Directed bench for sonar_range_filter with a cycle-level reference model.
module tb_sonar_range_filter;

    localparam int WD = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        raw_valid;
    logic [31:0] raw_dist;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        obstacle;
    logic        stale;
    logic        overrun;

    always #5 clk = ~clk;

    sonar_range_filter #(.WATCHDOG_CYCLES(WD)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_valid  (raw_valid),
        .raw_dist   (raw_dist),
        .dist_mm    (dist_mm),
        .dist_valid (dist_valid),
        .obstacle   (obstacle),
        .stale      (stale),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint edge_n     = 0;
    longint busy_end   = -1;
    longint last_clear = 0;
    longint pend_edge  = -1;
    int     pend_val   = 0;
    int     hist[$];
    bit     model_live = 0;
    int     e_mm = 6000;
    bit     e_dv = 0, e_obs = 0, e_stale = 0, e_ovr = 0;

    function automatic int scale_mm(input longint raw);
        longint m;
        if (raw >= 1_900_000) return 6000;
        m = (raw * 225) / 65536;
        return (m > 6000) ? 6000 : int'(m);
    endfunction

    function automatic int filt_model();
        int v[$];
        v = hist;
        if (v.size() == 1) return v[0];
        if (v.size() == 2) return (v[0] < v[1]) ? v[0] : v[1];
        v.sort();
        return v[1];
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            hist.delete();
            busy_end   = -1;
            last_clear = edge_n;
            pend_edge  = -1;
            e_mm = 6000; e_dv = 0; e_obs = 0; e_stale = 0; e_ovr = 0;
            model_live = 1;
        end else begin
            if (raw_valid) begin
                if (edge_n > busy_end) begin
                    hist.push_front(scale_mm(longint'(raw_dist)));
                    if (hist.size() > 3) void'(hist.pop_back());
                    pend_val   = filt_model();
                    pend_edge  = edge_n + 2;
                    busy_end   = edge_n + 3;
                    last_clear = edge_n;
                end else begin
                    e_ovr = 1;
                end
            end
            e_dv = (edge_n == pend_edge);
            if (e_dv) begin
                e_mm = pend_val;
                if (e_mm < 300) e_obs = 1;
                else if (e_mm > 350) e_obs = 0;
                e_stale = 0;
            end else if (edge_n - last_clear >= WD) begin
                e_stale = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_live) begin
            chk("m_dist_valid", dist_valid, e_dv);
            chk("m_dist_mm",    dist_mm,    e_mm);
            chk("m_obstacle",   obstacle,   e_obs);
            chk("m_stale",      stale,      e_stale);
            chk("m_overrun",    overrun,    e_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] r);
        @(negedge clk); raw_valid = 1'b1; raw_dist = r;
        @(negedge clk); raw_valid = 1'b0;
    endtask

    // Called one negedge after the accepting edge; expects dist_valid 3 cycles after the strobe.
    task automatic expect_out(input string name, input int mm, input bit obs);
        int k = 1;
        while (!dist_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_lat"}, k, 3);
        chk({name, "_mm"},  dist_mm, mm);
        chk({name, "_obs"}, obstacle, obs);
    endtask

    int hy_raw[12] = '{291300, 291300, 291300, 84469, 84469, 84469,
                       99033, 99033, 99033, 102237, 102237, 102237};
    int hy_mm [12] = '{1000, 1000, 1000, 1000, 290, 290, 290, 340, 340, 340, 351, 351};
    bit hy_obs[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        #100000;
        n_errors++;
        $display("FAIL global_timeout: got %0d expected 0 (simulation did not finish)", 1);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; raw_valid = 1'b0; raw_dist = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_dist_mm", dist_mm, 6000);
        chk("rst_dist_valid", dist_valid, 0);
        chk("rst_obstacle", obstacle, 0);
        chk("rst_stale", stale, 0);
        chk("rst_overrun", overrun, 0);

        // Scaling and fill sequence
        send(32'd291300); expect_out("fill1", 1000, 0); idle(6);
        send(32'd58260);  expect_out("fill2", 200, 1);  idle(6);
        send(32'd291300); expect_out("fill3", 1000, 0); idle(6);

        // Hysteresis
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(32'(hy_raw[i]));
            expect_out($sformatf("hyst%0d", i), hy_mm[i], hy_obs[i]);
            idle(4);
        end

        // Timeout and clamp
        do_reset(); send(32'd1_900_000); expect_out("timeout", 6000, 0); idle(3);
        do_reset(); send(32'd1_899_999); expect_out("clamp", 6000, 0); idle(3);
        do_reset(); send(32'd0); expect_out("zero", 0, 1); idle(3);

        // Overrun: second strobe one cycle later, then one at N+4
        do_reset();
        @(negedge clk); raw_valid = 1'b1; raw_dist = 32'd291300;
        @(negedge clk); raw_dist = 32'd58260;
        @(negedge clk); raw_valid = 1'b0;
        @(negedge clk);
        chk("ovr_dv", dist_valid, 1);
        chk("ovr_mm", dist_mm, 1000);
        chk("ovr_flag", overrun, 1);
        @(negedge clk); raw_valid = 1'b1; raw_dist = 32'd58260;
        @(negedge clk); raw_valid = 1'b0;
        expect_out("ovr_next", 200, 1);
        idle(5);
        chk("ovr_sticky", overrun, 1);
        do_reset();
        chk("ovr_cleared", overrun, 0);

        // Watchdog
        send(32'd291300); expect_out("wd_first", 1000, 0);
        idle(97);
        chk("wd_not_yet", stale, 0);
        idle(1);
        chk("wd_stale", stale, 1);
        chk("wd_dist_hold", dist_mm, 1000);
        idle(5);
        send(32'd58260); expect_out("wd_next", 200, 1);
        chk("wd_cleared", stale, 0);
        idle(4);

        // Reset during SCALE
        do_reset();
        send(32'd291300); expect_out("rm_a", 1000, 0); idle(4);
        send(32'd291300); expect_out("rm_b", 1000, 0); idle(4);
        @(negedge clk); raw_valid = 1'b1; raw_dist = 32'd291300;
        @(negedge clk); raw_valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rm_mm", dist_mm, 6000);
        chk("rm_obs", obstacle, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rm_no_dv", dist_valid, 0);
        end
        send(32'd58260); expect_out("rm_restart", 200, 1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
